proximity_alert: RTL and testbench

Downstream consumer of the ultrasonic echo-width stage. It samples the 9-bit `distance` value (cm) at a fixed rate and smooths it with a 4-sample moving average. It classifies the result into CLEAR / WARN / CRIT with hysteresis and de-escalation confirmation, and drives the alert level and buzzer of the crash-detection top level.

---
 rtl/proximity_alert.sv | 190 +++++++++++++++++++
 tb/tb_proximity_alert.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proximity_alert.sv
// proximity_alert: samples an echo distance at a fixed rate, smooths it over a
// 4-sample window and classifies it into CLEAR / WARN / CRIT with hysteresis
// and de-escalation confirmation. It drives the alert level and the buzzer.
// Optional feature macro: CLOSING_RATE_EN (fast-approach detection).
module proximity_alert #(
   parameter int unsigned SAMPLE_TICKS = 50000,
   parameter int unsigned WARN_DIST    = 100,
   parameter int unsigned CRIT_DIST    = 30,
   parameter int unsigned HYST         = 10,
   parameter int unsigned CONFIRM      = 3,
   parameter int unsigned BEEP_HALF    = 12500000,
   parameter int unsigned RATE_THRESH  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] distance,
   output logic [1:0] alert_level,
   output logic       buzzer,
   output logic [8:0] avg_distance,
   output logic       sample_strobe,
   output logic       closing
);

   localparam int unsigned TW = $clog2(SAMPLE_TICKS);
   localparam int unsigned BW = $clog2(BEEP_HALF + 1);
   localparam int unsigned CW = $clog2(CONFIRM + 1);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_WARN  = 2'd1;
   localparam logic [1:0] ST_CRIT  = 2'd2;

   logic [TW-1:0] r_tick;
   logic [8:0]    r_win [4];
   logic          r_strobe;
   logic [8:0]    r_avg;
   logic          r_closing;
   logic [1:0]    r_state;
   logic [CW-1:0] r_conf;
   logic [BW-1:0] r_beep_cnt;
   logic          r_beep_ph;

   logic          w_wrap;
   logic [10:0]   w_sum;
   logic [8:0]    w_avg;
   logic [31:0]   w_avg_ext;
   logic [1:0]    w_cand;
   logic [1:0]    w_cand_adj;
   logic          w_closing;
   logic          w_qual;
   logic [1:0]    w_target;
   logic [1:0]    w_state_d;
   logic [CW-1:0] w_conf_d;

   assign w_wrap    = (r_tick == TW'(SAMPLE_TICKS - 1));
   assign w_sum     = {2'b00, r_win[0]} + {2'b00, r_win[1]} + {2'b00, r_win[2]} + {2'b00, r_win[3]};
   assign w_avg     = w_sum[10:2];
   assign w_avg_ext = {23'd0, w_avg};

   // Sample-period tick counter, wraps every SAMPLE_TICKS cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick <= '0;
      end else if (w_wrap) begin
         r_tick <= '0;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

   // Shift the current distance into the window on the wrap edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_win[i] <= 9'd511;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= w_wrap;
         if (w_wrap) begin
            r_win[0] <= distance;
            for (int i = 1; i < 4; i++) r_win[i] <= r_win[i-1];
         end
      end
   end

   // Zone candidate from the freshly shifted window
   always_comb begin
      w_cand = ST_CLEAR;
      if (w_avg_ext < CRIT_DIST) begin
         w_cand = ST_CRIT;
      end else if (w_avg_ext < WARN_DIST) begin
         w_cand = ST_WARN;
      end
   end

`ifdef CLOSING_RATE_EN
   // r_avg still holds the previous sample's average when this is evaluated
   assign w_closing  = (r_avg > w_avg) && ({23'd0, r_avg - w_avg} > RATE_THRESH);
   assign w_cand_adj = (w_closing && (w_cand != ST_CRIT)) ? (w_cand + 2'd1) : w_cand;
`else
   logic w_unused_rate;
   assign w_unused_rate = |RATE_THRESH;
   assign w_closing     = 1'b0;
   assign w_cand_adj    = w_cand;
`endif

   // Escalate at once; de-escalate only after CONFIRM consecutive qualifying samples
   always_comb begin
      w_state_d = r_state;
      w_conf_d  = r_conf;
      w_qual    = 1'b0;
      w_target  = r_state;
      if (r_strobe) begin
         if (w_cand_adj > r_state) begin
            w_state_d = w_cand_adj;
            w_conf_d  = '0;
         end else begin
            case (r_state)
               ST_CRIT: begin
                  if (w_avg_ext >= CRIT_DIST + HYST) begin
                     w_qual   = 1'b1;
                     w_target = (w_avg_ext >= WARN_DIST + HYST) ? ST_CLEAR : ST_WARN;
                  end
               end
               ST_WARN: begin
                  if (w_avg_ext >= WARN_DIST + HYST) begin
                     w_qual   = 1'b1;
                     w_target = ST_CLEAR;
                  end
               end
               default: ;
            endcase
            if (w_closing) w_qual = 1'b0;
            if (w_qual) begin
               if ({{(32-CW){1'b0}}, r_conf} + 32'd1 >= CONFIRM) begin
                  w_state_d = w_target;
                  w_conf_d  = '0;
               end else begin
                  w_conf_d = r_conf + 1'b1;
               end
            end else begin
               w_conf_d = '0;
            end
         end
      end
   end

   // Classification state, average and closing flag update one cycle after sampling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_conf    <= '0;
         r_avg     <= 9'd511;
         r_closing <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_conf  <= w_conf_d;
         if (r_strobe) begin
            r_avg     <= w_avg;
            r_closing <= w_closing;
         end
      end
   end

   // WARN beep generator; restarts high on every entry into WARN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beep_cnt <= '0;
         r_beep_ph  <= 1'b0;
      end else if (w_state_d == ST_WARN) begin
         if (r_state != ST_WARN) begin
            r_beep_cnt <= '0;
            r_beep_ph  <= 1'b1;
         end else if (r_beep_cnt == BW'(BEEP_HALF - 1)) begin
            r_beep_cnt <= '0;
            r_beep_ph  <= ~r_beep_ph;
         end else begin
            r_beep_cnt <= r_beep_cnt + 1'b1;
         end
      end else begin
         r_beep_cnt <= '0;
         r_beep_ph  <= 1'b0;
      end
   end

   assign alert_level   = r_state;
   assign buzzer        = (r_state == ST_CRIT) | ((r_state == ST_WARN) & r_beep_ph);
   assign avg_distance  = r_avg;
   assign sample_strobe = r_strobe;
   assign closing       = r_closing;

endmodule

// File: tb/tb_proximity_alert.sv
// Self-checking bench for proximity_alert: table-driven sample sequences,
// randomized samples against a behavioural model, and a mid-alert reset.
module tb_proximity_alert;

   localparam int ST     = 4;
   localparam int BH     = 3;
   localparam int WARN_D = 100;
   localparam int CRIT_D = 30;
   localparam int HYS    = 10;
   localparam int CONF   = 3;
   localparam int RATE   = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] distance = 9'd200;
   logic [1:0] alert_level;
   logic       buzzer;
   logic [8:0] avg_distance;
   logic       sample_strobe;
   logic       closing;

   proximity_alert #(
      .SAMPLE_TICKS (ST),
      .WARN_DIST    (WARN_D),
      .CRIT_DIST    (CRIT_D),
      .HYST         (HYS),
      .CONFIRM      (CONF),
      .BEEP_HALF    (BH),
      .RATE_THRESH  (RATE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .distance      (distance),
      .alert_level   (alert_level),
      .buzzer        (buzzer),
      .avg_distance  (avg_distance),
      .sample_strobe (sample_strobe),
      .closing       (closing)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int m_cyc;
   int m_win[4];
   int m_avg;
   int m_lvl;
   int m_conf;
   int m_cls;
   int m_warn_t;

   typedef struct {
      int d;
      int avg;
      int lvl_off;
      int lvl_on;
      int cls_on;
   } row_t;

   row_t rows[$];

   function automatic void add(int d, int a, int lo, int ln, int cn);
      row_t r;
      r.d = d; r.avg = a; r.lvl_off = lo; r.lvl_on = ln; r.cls_on = cn;
      rows.push_back(r);
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0;
      for (int i = 0; i < 4; i++) m_win[i] = 511;
      m_avg = 511; m_lvl = 0; m_conf = 0; m_cls = 0; m_warn_t = 0;
   endtask

   task automatic set_level(int nl);
      if (nl == 1 && m_lvl != 1) m_warn_t = 0;
      m_lvl = nl;
   endtask

   // One sample's classification, straight from the zone/hysteresis rules
   task automatic model_eval();
      int avg, cand, cls, qual, tgt;
      avg = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
      cls = 0;
`ifdef CLOSING_RATE_EN
      if (m_avg - avg > RATE) cls = 1;
`endif
      m_avg = avg;
      m_cls = cls;
      cand = (avg < CRIT_D) ? 2 : (avg < WARN_D) ? 1 : 0;
      if (cls != 0 && cand < 2) cand++;
      if (cand > m_lvl) begin
         set_level(cand);
         m_conf = 0;
      end else begin
         qual = 0;
         tgt  = m_lvl;
         if (m_lvl == 2 && avg >= CRIT_D + HYS) begin
            qual = 1;
            tgt  = (avg >= WARN_D + HYS) ? 0 : 1;
         end else if (m_lvl == 1 && avg >= WARN_D + HYS) begin
            qual = 1;
            tgt  = 0;
         end
         if (cls != 0) qual = 0;
         if (qual != 0) begin
            m_conf++;
            if (m_conf == CONF) begin
               set_level(tgt);
               m_conf = 0;
            end
         end else begin
            m_conf = 0;
         end
      end
   endtask

   // Advance one clock, update the model and compare every output
   task automatic cycle();
      logic [8:0] d_edge;
      int exp_strobe, exp_buzz;
      d_edge = distance;
      @(posedge clk);
      #1;
      m_cyc++;
      if (m_lvl == 1) m_warn_t++;
      exp_strobe = 0;
      if (m_cyc % ST == 0) begin
         for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
         m_win[0]   = int'(d_edge);
         exp_strobe = 1;
      end else if (m_cyc % ST == 1 && m_cyc > 1) begin
         model_eval();
      end
      exp_buzz = (m_lvl == 2) ? 1 : (m_lvl == 1) ? (((m_warn_t / BH) % 2 == 0) ? 1 : 0) : 0;
      check("strobe", int'(sample_strobe), exp_strobe);
      check("level", int'(alert_level), m_lvl);
      check("buzzer", int'(buzzer), exp_buzz);
      check("avg", int'(avg_distance), m_avg);
      check("closing", int'(closing), m_cls);
   endtask

   // Drive d up to the next sampling edge, then step past the update edge
   task automatic do_sample(int d, bit junk);
      do begin
         if (junk && ((m_cyc + 1) % ST != 0)) distance = 9'($urandom_range(0, 511));
         else distance = 9'(d);
         cycle();
      end while (m_cyc % ST != 0);
      distance = 9'(d);
      cycle();
   endtask

   initial begin
      int prev_d, pick, d, n, exp_lvl, exp_cls;

      // Prefill, hold, approach to CRIT, hysteresis, release, closing step
      for (int i = 0; i < 4; i++) add(200, (i == 0) ? 433 : (i == 1) ? 355 : (i == 2) ? 277 : 200,
                                      0, 1, 1);
      add(200, 200, 0, 1, 0); add(200, 200, 0, 1, 0);
      for (int i = 0; i < 6; i++) add(200, 200, 0, 0, 0);
      add(20, 155, 0, 1, 1); add(20, 110, 0, 1, 1); add(20, 65, 1, 2, 1); add(20, 20, 2, 2, 1);
      add(35, 23, 2, 2, 0);  add(35, 27, 2, 2, 0);  add(35, 31, 2, 2, 0); add(35, 35, 2, 2, 0);
      add(45, 37, 2, 2, 0);  add(45, 40, 2, 2, 0);  add(45, 42, 2, 2, 0); add(45, 45, 1, 1, 0);
      add(200, 83, 1, 1, 0); add(200, 122, 1, 1, 0); add(200, 161, 1, 1, 0);
      for (int i = 0; i < 5; i++) add(200, 200, 0, 0, 0);
      add(100, 175, 0, 1, 1); add(100, 150, 0, 1, 1); add(100, 125, 0, 1, 1);
      add(100, 100, 0, 1, 1);

      // Reset state, checked while reset is held
      repeat (3) @(posedge clk);
      #1;
      check("rst_level", int'(alert_level), 0);
      check("rst_buzzer", int'(buzzer), 0);
      check("rst_avg", int'(avg_distance), 511);
      check("rst_strobe", int'(sample_strobe), 0);
      check("rst_closing", int'(closing), 0);
      rst = 1'b0;
      model_reset();

      foreach (rows[k]) begin
         do_sample(rows[k].d, 1'b0);
`ifdef CLOSING_RATE_EN
         exp_lvl = rows[k].lvl_on;
         exp_cls = rows[k].cls_on;
`else
         exp_lvl = rows[k].lvl_off;
         exp_cls = 0;
`endif
         check("tbl_avg", int'(avg_distance), rows[k].avg);
         check("tbl_level", int'(alert_level), exp_lvl);
         check("tbl_closing", int'(closing), exp_cls);
      end

      // Randomized samples, with junk on distance between sampling edges
      prev_d = 200;
      for (int s = 0; s < 80; s++) begin
         pick = int'($urandom_range(0, 4));
         case (pick)
            0: d = int'($urandom_range(0, 511));
            1: d = int'($urandom_range(0, 60));
            2: d = int'($urandom_range(80, 130));
            3: d = int'($urandom_range(25, 45));
            default: d = prev_d;
         endcase
         prev_d = d;
         do_sample(d, ($urandom_range(0, 1) == 1));
      end

      // Drive to CRIT at contact range, then reset mid-sample
      for (int s = 0; s < 4; s++) do_sample(0, 1'b0);
      check("crit_level", int'(alert_level), 2);
      check("crit_buzzer", int'(buzzer), 1);
      check("crit_avg", int'(avg_distance), 0);
      cycle();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_level", int'(alert_level), 0);
      check("async_rst_buzzer", int'(buzzer), 0);
      check("async_rst_avg", int'(avg_distance), 511);
      check("async_rst_strobe", int'(sample_strobe), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      distance = 9'd200;
      n = 0;
      while (sample_strobe == 1'b0 && n < 12) begin
         cycle();
         n++;
      end
      check("first_strobe_delay", n, ST);
      for (int s = 0; s < 3; s++) do_sample(200, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
